// File: rtl/mpu_fetch.sv
// MPU instruction fetch stage: keeps at most one instruction-memory read in flight and
// buffers the returned words in a 2-entry prefetch FIFO for decode/execute.
module mpu_fetch #(
    parameter int addr_width = 10,
    parameter int mem_size   = 1024
) (
    input  logic                  mpu_clk,
    input  logic                  sys_rst_n,
    input  logic                  mpu_en,
    input  logic                  mpu_rst,
    output logic                  imem_req,
    output logic [addr_width-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_data,
    output logic                  ins_valid,
    output logic [31:0]           ins_data,
    output logic [addr_width-1:0] ins_addr,
    input  logic                  ins_ready,
    input  logic                  jmp_en,
    input  logic [addr_width-1:0] jmp_addr,
    output logic                  error
);

    logic [addr_width-1:0] fpc;
    logic [addr_width-1:0] next_pc;
    logic [31:0]           fifo_data [2];
    logic [addr_width-1:0] fifo_addr [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic                  discard;
    logic                  complete;
    logic                  jump;
    logic                  push;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  room;
    logic                  want;
    logic                  in_range;
    logic                  issue;

    assign complete  = imem_req & imem_ack;
    assign jump      = mpu_en & jmp_en & ~mpu_rst;
    assign push      = complete & ~discard & ~jump & ~mpu_rst;
    assign ins_valid = (count != 2'd0) & mpu_en;
    assign pop       = ins_valid & ins_ready & ~jump & ~mpu_rst;
    assign wr_ptr    = rd_ptr ^ count[0];
    assign ins_data  = fifo_data[rd_ptr];
    assign ins_addr  = fifo_addr[rd_ptr];

    // A response landing this cycle already names the next address, so the
    // following request can go out back-to-back without waiting for fpc.
    assign next_pc   = (complete & ~discard) ? imem_addr + addr_width'(1) : fpc;
    assign occupancy = {1'b0, count} + {2'b00, imem_req} - {2'b00, pop};
    assign room      = occupancy < 3'd2;
    assign want      = mpu_en & ~error & ~mpu_rst & ~jump & (~imem_req | complete) & room;
    assign in_range  = 32'(next_pc) < 32'(mem_size);
    assign issue     = want & in_range;

    always_ff @(posedge mpu_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fpc       <= '0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            discard   <= 1'b0;
            error     <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            if (complete) begin
                discard <= 1'b0;
            end
            if (mpu_rst | jump) begin
                count <= 2'd0;
                fpc   <= mpu_rst ? '0 : jmp_addr;
                // The in-flight request cannot be withdrawn, so its answer is dropped later
                if (imem_req & ~imem_ack) begin
                    discard <= 1'b1;
                end
                if (mpu_rst) begin
                    error <= 1'b0;
                end
            end else begin
                if (push) begin
                    fifo_data[wr_ptr] <= imem_data;
                    fifo_addr[wr_ptr] <= imem_addr;
                    fpc               <= next_pc;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                if (push & ~pop) begin
                    count <= count + 2'd1;
                end else if (pop & ~push) begin
                    count <= count - 2'd1;
                end
                if (want & ~in_range) begin
                    error <= 1'b1;
                end
            end
            imem_req <= issue | (imem_req & ~imem_ack);
            if (issue) begin
                imem_addr <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_mpu_fetch.sv
// Scoreboard bench for mpu_fetch: a full-range instance exercises streaming, stalls,
// jumps, wrap and enable/reset behaviour; a mem_size=8 instance exercises the range error.
module tb_mpu_fetch;

    localparam int aw = 10;

    logic mpu_clk = 1'b0;
    logic sys_rst_n;
    always #5 mpu_clk = ~mpu_clk;

    logic          a_en, a_rst, a_req, a_ack, a_valid, a_ready, a_jmp, a_err;
    logic [aw-1:0] a_addr, a_ins_addr, a_jaddr;
    logic [31:0]   a_data, a_ins_data;
    int            a_delay = 0;
    int            a_wait  = 0;

    logic          b_en, b_rst, b_req, b_ack, b_valid, b_err;
    logic [aw-1:0] b_addr, b_ins_addr;
    logic [31:0]   b_data, b_ins_data;

    logic [aw-1:0] a_exp [$];
    logic [aw-1:0] b_exp [$];
    int            a_pops = 0;
    int            b_pops = 0;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            first_pop_cyc = 0;
    int            tenth_pop_cyc = 0;
    logic          hold_prev = 1'b0;
    logic [aw-1:0] addr_prev = '0;

    function automatic logic [31:0] mem_word(input logic [aw-1:0] a);
        return 32'(a) ^ 32'hA5A5_0000;
    endfunction

    // Instruction memories: A acks after a programmable number of wait cycles, B is zero-wait
    assign a_ack  = a_req && (a_wait >= a_delay);
    assign a_data = mem_word(a_addr);
    assign b_ack  = b_req;
    assign b_data = mem_word(b_addr);

    always @(posedge mpu_clk) begin
        a_wait <= (a_req && !a_ack) ? a_wait + 1 : 0;
        cyc    <= cyc + 1;
    end

    mpu_fetch #(.addr_width(aw), .mem_size(1024)) dut_a (
        .mpu_clk   (mpu_clk),
        .sys_rst_n (sys_rst_n),
        .mpu_en    (a_en),
        .mpu_rst   (a_rst),
        .imem_req  (a_req),
        .imem_addr (a_addr),
        .imem_ack  (a_ack),
        .imem_data (a_data),
        .ins_valid (a_valid),
        .ins_data  (a_ins_data),
        .ins_addr  (a_ins_addr),
        .ins_ready (a_ready),
        .jmp_en    (a_jmp),
        .jmp_addr  (a_jaddr),
        .error     (a_err)
    );

    mpu_fetch #(.addr_width(aw), .mem_size(8)) dut_b (
        .mpu_clk   (mpu_clk),
        .sys_rst_n (sys_rst_n),
        .mpu_en    (b_en),
        .mpu_rst   (b_rst),
        .imem_req  (b_req),
        .imem_addr (b_addr),
        .imem_ack  (b_ack),
        .imem_data (b_data),
        .ins_valid (b_valid),
        .ins_data  (b_ins_data),
        .ins_addr  (b_ins_addr),
        .ins_ready (1'b1),
        .jmp_en    (1'b0),
        .jmp_addr  ('0),
        .error     (b_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ready, input logic jmp, input logic [aw-1:0] jaddr);
        a_en    = en;
        a_ready = ready;
        a_jmp   = jmp;
        a_jaddr = jaddr;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge mpu_clk);
        #1;
    endtask

    task automatic waitPops(input bit use_b, input int target, input int budget);
        int n = 0;
        while ((use_b ? b_pops : a_pops) < target && n < budget) begin
            @(posedge mpu_clk);
            n++;
        end
        #1;
        checks++;
        if ((use_b ? b_pops : a_pops) < target) begin
            errors++;
            $display("[TB] FAIL %s pop timeout: actual %0d pops, required %0d",
                     use_b ? "b" : "a", use_b ? b_pops : a_pops, target);
        end
    endtask

    task automatic pushA(input int lo, input int n);
        for (int k = 0; k < n; k++) a_exp.push_back(aw'(lo + k));
    endtask

    task automatic pushB(input int lo, input int n);
        for (int k = 0; k < n; k++) b_exp.push_back(aw'(lo + k));
    endtask

    // Monitor for A: scoreboard pop on every accepted head, plus request stability
    always @(negedge mpu_clk) begin
        logic [aw-1:0] exp_addr;
        if (sys_rst_n) begin
            if (hold_prev) begin
                checkOutput("a imem_req held", 32'(a_req), 32'd1);
                checkOutput("a imem_addr stable", 32'(a_addr), 32'(addr_prev));
            end
            hold_prev = a_req && !a_ack;
            addr_prev = a_addr;
            if (a_valid && a_ready) begin
                if (a_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL a unexpected head: actual ins_addr %0h, required none", a_ins_addr);
                end else begin
                    exp_addr = a_exp.pop_front();
                    checkOutput("a ins_addr", 32'(a_ins_addr), 32'(exp_addr));
                    checkOutput("a ins_data", a_ins_data, mem_word(exp_addr));
                end
                a_pops++;
                if (a_pops == 1) first_pop_cyc = cyc;
                if (a_pops == 10) tenth_pop_cyc = cyc;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    always @(negedge mpu_clk) begin
        logic [aw-1:0] exp_addr;
        if (sys_rst_n && b_valid) begin
            if (b_exp.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b unexpected head: actual ins_addr %0h, required none", b_ins_addr);
            end else begin
                exp_addr = b_exp.pop_front();
                checkOutput("b ins_addr", 32'(b_ins_addr), 32'(exp_addr));
                checkOutput("b ins_data", b_ins_data, mem_word(exp_addr));
            end
            b_pops++;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sys_rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        a_rst = 1'b0;
        b_en  = 1'b0;
        b_rst = 1'b0;
        #12;
        checkOutput("reset imem_req", 32'(a_req), 32'd0);
        checkOutput("reset imem_addr", 32'(a_addr), 32'd0);
        checkOutput("reset ins_valid", 32'(a_valid), 32'd0);
        checkOutput("reset ins_data", a_ins_data, 32'd0);
        checkOutput("reset ins_addr", 32'(a_ins_addr), 32'd0);
        checkOutput("reset error", 32'(a_err), 32'd0);
        @(posedge mpu_clk);
        #1;
        sys_rst_n = 1'b1;
        waitCycles(2);

        // Streaming from address 0 with a zero-wait memory
        pushA(0, 10);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("req before first issue", 32'(a_req), 32'd0);
        waitCycles(1);
        checkOutput("first req", 32'(a_req), 32'd1);
        checkOutput("first req addr", 32'(a_addr), 32'd0);
        waitPops(1'b0, 10, 40);
        checkOutput("throughput cycles for 10", 32'(tenth_pop_cyc - first_pop_cyc), 32'd9);

        // Downstream stall: two words buffered, requests stop, then resume without loss
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        waitCycles(4);
        checkOutput("stall imem_req", 32'(a_req), 32'd0);
        checkOutput("stall ins_valid", 32'(a_valid), 32'd1);
        checkOutput("stall head", 32'(a_ins_addr), 32'd10);
        pushA(10, 10);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        waitCycles(1);
        checkOutput("resume req", 32'(a_req), 32'd1);
        checkOutput("resume req addr", 32'(a_addr), 32'd12);
        checkOutput("resume head", 32'(a_ins_addr), 32'd11);
        waitPops(1'b0, 20, 40);

        // Slow memory: jump to 5, then redirect to 0x40 while 5 is still outstanding
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        waitCycles(4);
        a_delay = 3;
        applyStimulus(1'b1, 1'b0, 1'b1, aw'(5));
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("jump flush valid", 32'(a_valid), 32'd0);
        checkOutput("jump cycle req", 32'(a_req), 32'd0);
        waitCycles(1);
        checkOutput("jump target req", 32'(a_req), 32'd1);
        checkOutput("jump target addr", 32'(a_addr), 32'd5);
        pushA(32'h40, 4);
        applyStimulus(1'b1, 1'b1, 1'b1, aw'(32'h40));
        waitCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("held addr after jump", 32'(a_addr), 32'd5);
        waitCycles(3);
        checkOutput("redirect req addr", 32'(a_addr), 32'h40);
        checkOutput("discarded word not valid", 32'(a_valid), 32'd0);
        waitPops(1'b0, 24, 60);

        // Address wrap at 2^addr_width is legal when mem_size covers the whole space
        a_delay = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, aw'(1022));
        pushA(1022, 5);
        waitCycles(1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        waitPops(1'b0, 29, 40);
        checkOutput("wrap error", 32'(a_err), 32'd0);

        // mpu_en dropped while a request is outstanding
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        waitCycles(4);
        a_delay = 3;
        applyStimulus(1'b1, 1'b0, 1'b1, aw'(32'h100));
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        waitCycles(1);
        checkOutput("en-drop req addr", 32'(a_addr), 32'h100);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        waitCycles(5);
        checkOutput("disabled no issue", 32'(a_req), 32'd0);
        checkOutput("disabled valid", 32'(a_valid), 32'd0);
        pushA(32'h100, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        waitCycles(2);
        checkOutput("disabled valid with ready", 32'(a_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        #1;
        checkOutput("re-enable valid", 32'(a_valid), 32'd1);
        checkOutput("re-enable head", 32'(a_ins_addr), 32'h100);
        waitCycles(1);
        checkOutput("next req addr", 32'(a_addr), 32'h101);

        // Asynchronous reset in the middle of an outstanding request
        #3;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async imem_req", 32'(a_req), 32'd0);
        checkOutput("async imem_addr", 32'(a_addr), 32'd0);
        checkOutput("async ins_valid", 32'(a_valid), 32'd0);
        checkOutput("async ins_data", a_ins_data, 32'd0);
        checkOutput("async ins_addr", 32'(a_ins_addr), 32'd0);
        checkOutput("async error", 32'(a_err), 32'd0);
        checkOutput("a scoreboard drained", 32'(a_exp.size()), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        @(posedge mpu_clk);
        #1;
        sys_rst_n = 1'b1;
        waitCycles(1);

        // mem_size=8: addresses 0..7, then a sticky error until mpu_rst
        pushB(0, 8);
        b_en = 1'b1;
        waitPops(1'b1, 8, 40);
        waitCycles(2);
        checkOutput("b error raised", 32'(b_err), 32'd1);
        checkOutput("b req after error", 32'(b_req), 32'd0);
        checkOutput("b drained", 32'(b_valid), 32'd0);
        b_rst = 1'b1;
        waitCycles(1);
        b_rst = 1'b0;
        checkOutput("b error cleared", 32'(b_err), 32'd0);
        pushB(0, 8);
        waitCycles(1);
        checkOutput("b restart req", 32'(b_req), 32'd1);
        checkOutput("b restart addr", 32'(b_addr), 32'd0);
        waitPops(1'b1, 16, 40);
        waitCycles(2);
        checkOutput("b error again", 32'(b_err), 32'd1);
        checkOutput("b scoreboard drained", 32'(b_exp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
